// File: rtl/freq_spectrum_capture.sv
// Captures one frame of the lower NBINS FFT bins into ping-pong RAM banks and publishes it to the display.
// Optional macro PEAK_DETECT_EN builds the per-frame peak tracker; without it peakBin/peakMag read 0.
module freq_spectrum_capture #(
    parameter int unsigned NBINS = 512,
    parameter int unsigned ABITS = 9
) (
    input  logic             ckFreq,
    input  logic             reset,
    input  logic             flgFreqSampleValid,
    input  logic [9:0]       addrFreq,
    input  logic [7:0]       byteFreqSample,
    input  logic             flgFreeze,
    input  logic [ABITS-1:0] rdAddr,
    output logic [7:0]       rdData,
    output logic             flgFrameReady,
    output logic             flgSyncErr,
    output logic [ABITS-1:0] peakBin,
    output logic [7:0]       peakMag,
    output logic [15:0]      cntFrames
);

    typedef enum logic [1:0] {
        stIdle,
        stCapture,
        stPublish
    } state_t;

    state_t           state_q, state_d;
    logic [ABITS-1:0] expected_q, expected_d;
    logic             wrBank_q, wrBank_d;
    logic             frameReady_q, frameReady_d;
    logic             syncErr_q, syncErr_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [7:0]       rdData_q;
    logic [7:0]       bankMem [2*NBINS];

    logic             sampleOk, binIsZero, binIsLast;
    logic             startFrame, acceptBin, publish;
    logic [ABITS-1:0] bin;

    assign bin       = addrFreq[ABITS-1:0];
    assign sampleOk  = flgFreqSampleValid && ({1'b0, addrFreq} < 11'(NBINS));
    assign binIsZero = (bin == '0);
    assign binIsLast = (bin == ABITS'(NBINS - 1));
    assign publish   = (state_q == stPublish) && !flgFreeze;

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        wrBank_d     = wrBank_q;
        frameReady_d = 1'b0;
        syncErr_d    = 1'b0;
        cnt_d        = cnt_q;
        startFrame   = 1'b0;
        acceptBin    = 1'b0;

        case (state_q)
            stIdle: begin
                if (sampleOk && binIsZero) begin
                    startFrame = 1'b1;
                    state_d    = stCapture;
                end
            end
            stCapture: begin
                if (sampleOk) begin
                    if (binIsZero) begin
                        syncErr_d  = 1'b1;
                        startFrame = 1'b1;
                    end else if (bin == expected_q) begin
                        acceptBin = 1'b1;
                        if (binIsLast) state_d = stPublish;
                    end else begin
                        syncErr_d = 1'b1;
                        state_d   = stIdle;
                    end
                end
            end
            stPublish: begin
                state_d = stIdle;
                if (publish) begin
                    wrBank_d     = ~wrBank_q;
                    frameReady_d = 1'b1;
                    cnt_d        = cnt_q + 16'd1;
                end
                // A bin 0 arriving here lands in the freshly selected write bank
                if (sampleOk && binIsZero) begin
                    startFrame = 1'b1;
                    state_d    = stCapture;
                end
            end
            default: state_d = stIdle;
        endcase

        if (startFrame)     expected_d = ABITS'(1);
        else if (acceptBin) expected_d = expected_q + ABITS'(1);
    end

    always_ff @(posedge ckFreq or posedge reset) begin
        if (reset) begin
            state_q      <= stIdle;
            expected_q   <= '0;
            wrBank_q     <= 1'b0;
            frameReady_q <= 1'b0;
            syncErr_q    <= 1'b0;
            cnt_q        <= '0;
            rdData_q     <= '0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            wrBank_q     <= wrBank_d;
            frameReady_q <= frameReady_d;
            syncErr_q    <= syncErr_d;
            cnt_q        <= cnt_d;
            rdData_q     <= bankMem[{~wrBank_q, rdAddr}];
        end
    end

    always_ff @(posedge ckFreq) begin
        if (startFrame || acceptBin) bankMem[{wrBank_d, bin}] <= byteFreqSample;
    end

`ifdef PEAK_DETECT_EN
    logic [ABITS-1:0] runBin_q, peakBin_q;
    logic [7:0]       runMag_q, peakMag_q;

    always_ff @(posedge ckFreq or posedge reset) begin
        if (reset) begin
            runBin_q  <= '0;
            runMag_q  <= '0;
            peakBin_q <= '0;
            peakMag_q <= '0;
        end else begin
            // Strictly-greater update keeps the lowest bin on ties
            if (startFrame) begin
                runBin_q <= '0;
                runMag_q <= byteFreqSample;
            end else if (acceptBin && (byteFreqSample > runMag_q)) begin
                runBin_q <= bin;
                runMag_q <= byteFreqSample;
            end
            if (publish) begin
                peakBin_q <= runBin_q;
                peakMag_q <= runMag_q;
            end
        end
    end

    assign peakBin = peakBin_q;
    assign peakMag = peakMag_q;
`else
    assign peakBin = '0;
    assign peakMag = '0;
`endif

    assign rdData        = rdData_q;
    assign flgFrameReady = frameReady_q;
    assign flgSyncErr    = syncErr_q;
    assign cntFrames     = cnt_q;

endmodule

// File: tb/tb_freq_spectrum_capture.sv
// Scoreboard bench for freq_spectrum_capture: published frames are queued as they are streamed and matched on flgFrameReady.
module tb_freq_spectrum_capture;

    localparam int NBINS = 512;
    localparam int ABITS = 9;

    logic             ckFreq = 1'b0;
    logic             reset = 1'b0;
    logic             flgFreqSampleValid = 1'b0;
    logic [9:0]       addrFreq = '0;
    logic [7:0]       byteFreqSample = '0;
    logic             flgFreeze = 1'b0;
    logic [ABITS-1:0] rdAddr = '0;
    logic [7:0]       rdData;
    logic             flgFrameReady;
    logic             flgSyncErr;
    logic [ABITS-1:0] peakBin;
    logic [7:0]       peakMag;
    logic [15:0]      cntFrames;

    always #5 ckFreq = ~ckFreq;

    freq_spectrum_capture #(.NBINS(NBINS), .ABITS(ABITS)) dut (
        .ckFreq(ckFreq),
        .reset(reset),
        .flgFreqSampleValid(flgFreqSampleValid),
        .addrFreq(addrFreq),
        .byteFreqSample(byteFreqSample),
        .flgFreeze(flgFreeze),
        .rdAddr(rdAddr),
        .rdData(rdData),
        .flgFrameReady(flgFrameReady),
        .flgSyncErr(flgSyncErr),
        .peakBin(peakBin),
        .peakMag(peakMag),
        .cntFrames(cntFrames)
    );

    typedef struct {
        logic [ABITS-1:0] bin;
        logic [7:0]       mag;
        logic [15:0]      cnt;
    } pub_t;

    pub_t             exp_q[$];
    int               errors = 0;
    int               checks = 0;
    int               pulses = 0;
    int               syncs = 0;
    logic [15:0]      cnt_model = '0;
    logic [7:0]       ref_pub[NBINS];
    logic [7:0]       stage[NBINS];
    logic [ABITS-1:0] run_bin;
    logic [7:0]       run_mag;

    function automatic logic [7:0] pat(input int kind, input int a);
        if (kind == 0) return (a == 300) ? 8'hFF : 8'(a & 'h7F);
        if (kind == 1) begin
            if (a >= NBINS) return 8'hFF;
            if (a == 10 || a == 20) return 8'hF0;
            return 8'(a & 'h7F);
        end
        return 8'(kind);
    endfunction

    task automatic tick();
        @(posedge ckFreq);
        #1;
    endtask

    task automatic idle(input int n);
        flgFreqSampleValid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic stream(input int kind, input int first, input int last, input bit pub);
        pub_t p;
        logic [7:0] b;
        for (int a = first; a <= last; a++) begin
            b = pat(kind, a);
            flgFreqSampleValid = 1'b1;
            addrFreq = 10'(a);
            byteFreqSample = b;
            if (a < NBINS) stage[a] = b;
            if (a == 0) begin
                run_bin = '0;
                run_mag = b;
            end else if (a < NBINS && b > run_mag) begin
                run_bin = ABITS'(a);
                run_mag = b;
            end
            if (a == NBINS - 1 && pub) begin
                cnt_model = cnt_model + 16'd1;
`ifdef PEAK_DETECT_EN
                p.bin = run_bin;
                p.mag = run_mag;
`else
                p.bin = '0;
                p.mag = '0;
`endif
                p.cnt = cnt_model;
                exp_q.push_back(p);
                ref_pub = stage;
            end
            tick();
        end
        flgFreqSampleValid = 1'b0;
    endtask

    always begin
        pub_t p;
        @(posedge ckFreq);
        #2;
        if (flgFrameReady === 1'b1) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_pulse: got unexpected flgFrameReady, required none (cnt=%0d)", cntFrames);
            end else begin
                p = exp_q.pop_front();
                if ({peakBin, peakMag, cntFrames} !== {p.bin, p.mag, p.cnt}) begin
                    errors++;
                    $display("FAIL frame_publish: got bin=%0d mag=%h cnt=%0d, required bin=%0d mag=%h cnt=%0d",
                             peakBin, peakMag, cntFrames, p.bin, p.mag, p.cnt);
                end
            end
        end
        if (flgSyncErr === 1'b1) syncs++;
    end

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if ({rdData, flgFrameReady, flgSyncErr, peakBin, peakMag, cntFrames} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%h fr=%b se=%b pb=%0d pm=%h cnt=%0d, required all 0",
                     rdData, flgFrameReady, flgSyncErr, peakBin, peakMag, cntFrames);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_clean_frame();
        int rd_list[3] = '{5, 300, 511};
        stream(0, 0, 1023, 1'b1);
        idle(3);
        checks++;
        if (exp_q.size() != 0 || cntFrames !== 16'd1) begin
            errors++;
            $display("FAIL clean_publish: got cnt=%0d pending=%0d, required cnt=1 pending=0", cntFrames, exp_q.size());
        end
        foreach (rd_list[i]) begin
            rdAddr = ABITS'(rd_list[i]);
            tick();
            checks++;
            if (rdData !== ref_pub[rd_list[i]]) begin
                errors++;
                $display("FAIL clean_read[%0d]: got %h, required %h", rd_list[i], rdData, ref_pub[rd_list[i]]);
            end
        end
    endtask

    task automatic test_tie_ignore();
        int rd_list[3] = '{10, 20, 21};
        stream(1, 0, 1023, 1'b1);
        idle(3);
        checks++;
        if (exp_q.size() != 0 || cntFrames !== cnt_model) begin
            errors++;
            $display("FAIL tie_publish: got cnt=%0d pending=%0d, required cnt=%0d pending=0", cntFrames, exp_q.size(), cnt_model);
        end
        foreach (rd_list[i]) begin
            rdAddr = ABITS'(rd_list[i]);
            tick();
            checks++;
            if (rdData !== ref_pub[rd_list[i]]) begin
                errors++;
                $display("FAIL tie_read[%0d]: got %h, required %h", rd_list[i], rdData, ref_pub[rd_list[i]]);
            end
        end
    endtask

    task automatic test_sync_error();
        int s0 = syncs;
        int p0 = pulses;
        stream(8'h66, 0, 99, 1'b0);
        stream(8'h66, 150, 150, 1'b0);
        idle(3);
        checks++;
        if (syncs != s0 + 1 || pulses != p0) begin
            errors++;
            $display("FAIL sync_abort: got syncs=%0d pulses=%0d, required syncs=%0d pulses=%0d", syncs, pulses, s0 + 1, p0);
        end
        rdAddr = ABITS'(50);
        tick();
        checks++;
        if (rdData !== ref_pub[50]) begin
            errors++;
            $display("FAIL sync_hold_read: got %h, required %h", rdData, ref_pub[50]);
        end
        stream(8'h77, 0, 49, 1'b0);
        stream(8'h77, 0, NBINS - 1, 1'b1);
        idle(3);
        checks++;
        if (syncs != s0 + 2 || exp_q.size() != 0 || cntFrames !== cnt_model) begin
            errors++;
            $display("FAIL sync_restart: got syncs=%0d cnt=%0d pending=%0d, required syncs=%0d cnt=%0d pending=0",
                     syncs, cntFrames, exp_q.size(), s0 + 2, cnt_model);
        end
        rdAddr = ABITS'(77);
        tick();
        checks++;
        if (rdData !== 8'h77) begin
            errors++;
            $display("FAIL sync_restart_read: got %h, required 77", rdData);
        end
    endtask

    task automatic test_freeze();
        logic [15:0] c0;
        stream(8'h11, 0, NBINS - 1, 1'b1);
        idle(3);
        c0 = cnt_model;
        flgFreeze = 1'b1;
        stream(8'h22, 0, NBINS - 1, 1'b0);
        idle(3);
        rdAddr = ABITS'(123);
        tick();
        checks++;
        if (rdData !== 8'h11 || cntFrames !== c0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL freeze_hold: got rd=%h cnt=%0d pending=%0d, required rd=11 cnt=%0d pending=0",
                     rdData, cntFrames, exp_q.size(), c0);
        end
        flgFreeze = 1'b0;
        stream(8'h33, 0, NBINS - 1, 1'b1);
        idle(3);
        rdAddr = ABITS'(400);
        tick();
        checks++;
        if (rdData !== 8'h33 || cntFrames !== c0 + 16'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL freeze_release: got rd=%h cnt=%0d pending=%0d, required rd=33 cnt=%0d pending=0",
                     rdData, cntFrames, exp_q.size(), c0 + 16'd1);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] c0 = cnt_model;
        int p0 = pulses;
        stream(8'h44, 0, NBINS - 1, 1'b1);
        stream(8'h55, 0, NBINS - 1, 1'b1);
        idle(3);
        checks++;
        if (cntFrames !== c0 + 16'd2 || pulses != p0 + 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got cnt=%0d pulses=%0d, required cnt=%0d pulses=%0d",
                     cntFrames, pulses - p0, c0 + 16'd2, 2);
        end
        for (int a = 0; a < 2; a++) begin
            rdAddr = ABITS'(a * (NBINS - 1));
            tick();
            checks++;
            if (rdData !== 8'h55) begin
                errors++;
                $display("FAIL b2b_read[%0d]: got %h, required 55", a * (NBINS - 1), rdData);
            end
        end
    endtask

    task automatic test_async_reset();
        stream(8'h66, 0, 200, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({rdData, flgFrameReady, flgSyncErr, peakBin, peakMag, cntFrames} !== '0) begin
            errors++;
            $display("FAIL async_reset: got rd=%h fr=%b se=%b pb=%0d pm=%h cnt=%0d, required all 0",
                     rdData, flgFrameReady, flgSyncErr, peakBin, peakMag, cntFrames);
        end
        tick();
        reset = 1'b0;
        cnt_model = '0;
        exp_q.delete();
        tick();
        stream(0, 0, NBINS - 1, 1'b1);
        idle(3);
        checks++;
        if (cntFrames !== 16'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL async_recover: got cnt=%0d pending=%0d, required cnt=1 pending=0", cntFrames, exp_q.size());
        end
        rdAddr = ABITS'(300);
        tick();
        checks++;
        if (rdData !== 8'hFF) begin
            errors++;
            $display("FAIL async_recover_read: got %h, required ff", rdData);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_frame();
        test_tie_ignore();
        test_sync_error();
        test_freeze();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
